mem_access_unit: RTL and testbench

//  Parametrised MEM-stage access unit for the MIPS pipeline. Handles byte/half/word loads and stores.

---
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store unit for the MIPS pipeline.
//   - Handles byte, half and word accesses on a big-endian line.
//   - Builds store byte-enables and replicated store data.
//   - Sign- or zero-extends load data.
//   - Runs a req/ack handshake to a variable-latency memory port.
//   - Flags misaligned or reserved-size accesses, and a missing ack (timeout).
//
// Ports
//   clk, rst_b                 clock (rising edge), asynchronous active-low reset
//   req_valid/req_write        load/store present; 1 = store
//   req_size/req_unsigned      0 byte, 1 half, 2 word, 3 reserved; zero-extend loads
//   req_addr/req_wdata         effective address, store data (rt)
//   stall                      hold the pipeline
//   rdata/rdata_valid          extended load result, 1-cycle completion pulse
//   align_err/timeout_err      1-cycle error pulses
//   mem_req/mem_we/mem_addr    memory request (held until mem_ack), write, line address
//   mem_be/mem_wdata           byte enables (bit j covers mem_wdata[8j+7:8j]), store data
//   mem_ack/mem_rdata          completion and full-line read data
//
// Build option
//   MEM_LOADBUF_EN : one-entry load line buffer that short-cuts repeated
//                    loads from the same line.
module mem_access_unit #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT_W = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  stall,
   output logic [DATA_W-1:0]     rdata,
   output logic                  rdata_valid,
   output logic                  align_err,
   output logic                  timeout_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam int LANES = DATA_W / 8;
   localparam int OFF_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LANES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t               state;
   logic [TIMEOUT_W-1:0] cnt;
   logic [OFF_W-1:0]     lat_off;
   logic [1:0]           lat_size;
   logic                 lat_uns;
   logic                 lat_write;

   logic [OFF_W-1:0]     req_off;
   logic [3:0]           req_nbytes;
   logic                 misaligned;
   logic [LANES-1:0]     be_c;
   logic [DATA_W-1:0]    wdata_c;

   // Lane k sits at bits [DATA_W-1-8k -: 8]; shifting left by 8k brings the
   // first requested byte to the top, then a right shift right-justifies it.
   function automatic logic [DATA_W-1:0] extend_load(
      input logic [DATA_W-1:0] line,
      input logic [OFF_W-1:0]  off,
      input logic [1:0]        size,
      input logic              uns
   );
      logic        [DATA_W-1:0] shifted;
      logic signed [DATA_W-1:0] shifted_s;
      logic        [DATA_W-1:0] res;
      int                       sh;
      shifted   = line << (8 * int'(off));
      shifted_s = signed'(shifted);
      sh        = DATA_W - (8 << size);
      if (uns) res = shifted >> sh;
      else     res = shifted_s >>> sh;
      return res;
   endfunction

   always_comb begin
      be_c       = '0;
      wdata_c    = '0;
      req_off    = OFF_W'(req_addr & LINE_MASK);
      req_nbytes = 4'd1 << req_size;
      misaligned = (req_size == 2'd3) || (int'(req_nbytes) > LANES) ||
                   ((req_addr & (ADDR_W'(req_nbytes) - ADDR_W'(1))) != '0);
      // Enable bit j qualifies data byte j, i.e. big-endian lane LANES-1-j.
      for (int j = 0; j < LANES; j++) begin
         be_c[j] = ((LANES - 1 - j) >= int'(req_off)) &&
                   ((LANES - 1 - j) < int'(req_off) + int'(req_nbytes));
         wdata_c[8*j +: 8] = req_wdata[8*(j & (int'(req_nbytes) - 1)) +: 8];
      end
   end

`ifdef MEM_LOADBUF_EN
   logic              lb_valid;
   logic [ADDR_W-1:0] lb_addr;
   logic [DATA_W-1:0] lb_data;
   logic              lb_hit;
   assign lb_hit = lb_valid && (lb_addr == (req_addr & ~LINE_MASK));
`endif

   assign stall     = (state == S_WAIT) || ((state == S_IDLE) && req_valid && !misaligned);
   assign align_err = (state == S_IDLE) && req_valid && misaligned;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state       <= S_IDLE;
         cnt         <= '0;
         lat_off     <= '0;
         lat_size    <= '0;
         lat_uns     <= 1'b0;
         lat_write   <= 1'b0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         timeout_err <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_be      <= '0;
         mem_wdata   <= '0;
`ifdef MEM_LOADBUF_EN
         lb_valid    <= 1'b0;
         lb_addr     <= '0;
         lb_data     <= '0;
`endif
      end else begin
         rdata_valid <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid && !misaligned) begin
                  lat_off   <= req_off;
                  lat_size  <= req_size;
                  lat_uns   <= req_unsigned;
                  lat_write <= req_write;
`ifdef MEM_LOADBUF_EN
                  if (req_write && lb_hit) lb_valid <= 1'b0;
                  if (!req_write && lb_hit) begin
                     rdata       <= extend_load(lb_data, req_off, req_size, req_unsigned);
                     rdata_valid <= 1'b1;
                     state       <= S_RESP;
                  end else
`endif
                  begin
                     mem_req   <= 1'b1;
                     mem_we    <= req_write;
                     mem_addr  <= req_addr & ~LINE_MASK;
                     mem_be    <= be_c;
                     mem_wdata <= wdata_c;
                     cnt       <= TIMEOUT_W'(1);
                     state     <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // Ack takes priority over a timeout in the same cycle.
               if (mem_ack) begin
                  mem_req     <= 1'b0;
                  rdata_valid <= 1'b1;
                  if (!lat_write) rdata <= extend_load(mem_rdata, lat_off, lat_size, lat_uns);
`ifdef MEM_LOADBUF_EN
                  if (!lat_write) begin
                     lb_valid <= 1'b1;
                     lb_addr  <= mem_addr;
                     lb_data  <= mem_rdata;
                  end
`endif
                  state <= S_RESP;
               end else if (cnt == TIMEOUT_W'(TIMEOUT)) begin
                  mem_req     <= 1'b0;
                  rdata       <= '0;
                  timeout_err <= 1'b1;
`ifdef MEM_LOADBUF_EN
                  lb_valid    <= 1'b0;
`endif
                  state <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RESP: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (DATA_W=32, TIMEOUT=4).
// Stimulus pushes the expected memory request and completion into queues;
// two monitors pop and compare whenever the DUT raises mem_req or a
// completion/error pulse.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        stall, rdata_valid, align_err, timeout_err, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(8), .TIMEOUT(4)) dut (
      .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
      .align_err(align_err), .timeout_err(timeout_err), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  kind;      // {rdata_valid, timeout_err, align_err}
      logic        chk_data;
      logic [31:0] data;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic        chk_st;    // compare be/wdata (stores only)
      logic [3:0]  be;
      logic [31:0] wdata;
   } mreq_t;

   localparam logic [2:0] K_OK = 3'b100;
   localparam logic [2:0] K_TO = 3'b010;
   localparam logic [2:0] K_AL = 3'b001;

   resp_t resp_q[$];
   mreq_t mreq_q[$];
   int    n_checks = 0;
   int    n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic push_resp(input logic [2:0] kind, input logic cd, input logic [31:0] d);
      resp_t e;
      e.kind = kind; e.chk_data = cd; e.data = d;
      resp_q.push_back(e);
   endtask

   task automatic push_mreq(input logic [31:0] a, input logic we, input logic cs,
                            input logic [3:0] be, input logic [31:0] wd);
      mreq_t e;
      e.addr = a; e.we = we; e.chk_st = cs; e.be = be; e.wdata = wd;
      mreq_q.push_back(e);
   endtask

   // Completion / error monitor
   always @(negedge clk) begin
      resp_t e;
      if (rdata_valid || timeout_err || align_err) begin
         if (resp_q.size() == 0) begin
            chk("unexpected_resp", {29'd0, rdata_valid, timeout_err, align_err}, 32'd0);
         end else begin
            e = resp_q.pop_front();
            chk("resp_kind", {29'd0, rdata_valid, timeout_err, align_err}, {29'd0, e.kind});
            if (e.chk_data) chk("rdata", rdata, e.data);
         end
      end
   end

   // Memory request monitor: compares on the first cycle of each request
   logic mreq_prev = 1'b0;
   always @(negedge clk) begin
      mreq_t m;
      if (mem_req && !mreq_prev) begin
         if (mreq_q.size() == 0) begin
            chk("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
         end else begin
            m = mreq_q.pop_front();
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
            if (m.chk_st) begin
               chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
               chk("mem_wdata", mem_wdata, m.wdata);
            end
         end
      end
      mreq_prev = mem_req;
   end

   // Drives one request; ack_at = WAIT cycle (1-based) that sees mem_ack, -1 = never.
   task automatic access(input string nm, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int ack_at,
                         input logic [31:0] line, input int exp_stall);
      int st;
      bit done;
      st = 0;
      done = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd; mem_rdata = line;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
            break;
         end
         st++;
         mem_ack = (cyc == ack_at);
         @(posedge clk); #1;
         req_valid = 1'b0;
         mem_ack = 1'b0;
      end
      if (!done) chk({nm, "_done"}, 32'd0, 32'd1);
      chk({nm, "_stall"}, 32'(st), 32'(exp_stall));
      chk({nm, "_mreq_low"}, {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic store(input string nm, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input int ack_at, input logic [3:0] be,
                        input logic [31:0] exp_wd);
      push_mreq(addr & ~32'h3, 1'b1, 1'b1, be, exp_wd);
      push_resp(K_OK, 1'b0, 32'd0);
      access(nm, 1'b1, sz, 1'b0, addr, wd, ack_at, 32'h0, 1 + ack_at);
   endtask

   task automatic load(input string nm, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] line, input int ack_at,
                       input logic [31:0] exp_d);
      push_mreq(addr & ~32'h3, 1'b0, 1'b0, 4'h0, 32'h0);
      push_resp(K_OK, 1'b1, exp_d);
      access(nm, 1'b0, sz, uns, addr, 32'h0, ack_at, line, 1 + ack_at);
   endtask

   task automatic misalign(input string nm, input logic wr, input logic [1:0] sz,
                           input logic [31:0] addr);
      push_resp(K_AL, 1'b0, 32'd0);
      access(nm, wr, sz, 1'b0, addr, 32'hFFFF_FFFF, -1, 32'h0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      @(posedge clk); #1;
      rst_b = 1'b1;

      // Stores: lane steering, enables and replication
      store("sw_100",  2'd2, 32'h100, 32'hDEADBEEF, 2, 4'b1111, 32'hDEADBEEF);
      store("sb_103",  2'd0, 32'h103, 32'h000000A5, 1, 4'b0001, 32'hA5A5A5A5);
      store("sh_102",  2'd1, 32'h102, 32'h00001234, 1, 4'b0011, 32'h12341234);
      store("sb_100",  2'd0, 32'h100, 32'h11223344, 3, 4'b1000, 32'h44444444);
      store("sb_102",  2'd0, 32'h202, 32'h0000007E, 1, 4'b0010, 32'h7E7E7E7E);
      store("sh_100",  2'd1, 32'h100, 32'h11223344, 1, 4'b1100, 32'h33443344);

      // Loads: extraction and extension
      load("lb_101",  2'd0, 1'b0, 32'h101, 32'h1280FF00, 1, 32'hFFFFFF80);
      load("lbu_101", 2'd0, 1'b1, 32'h101, 32'h1280FF00, 2, 32'h00000080);
      load("lh_102",  2'd1, 1'b0, 32'h102, 32'h1280FF00, 1, 32'hFFFFFF00);
      load("lw_100",  2'd2, 1'b0, 32'h100, 32'h1280FF00, 3, 32'h1280FF00);
      load("lhu_100", 2'd1, 1'b1, 32'h100, 32'h1280FF00, 1, 32'h00001280);
      load("lb_102",  2'd0, 1'b0, 32'h102, 32'h1280FF00, 1, 32'hFFFFFFFF);
      load("lb_103",  2'd0, 1'b0, 32'h103, 32'h1280FF00, 1, 32'h00000000);
      load("lh_206",  2'd1, 1'b0, 32'h206, 32'h7F0180FE, 2, 32'hFFFF80FE);
      load("lbu_207", 2'd0, 1'b1, 32'h207, 32'h7F0180FE, 1, 32'h000000FE);
      load("lb_204",  2'd0, 1'b0, 32'h204, 32'h7F0180FE, 1, 32'h0000007F);

      // Misaligned / reserved size: one pulse, no stall, no memory request
      misalign("lw_102", 1'b0, 2'd2, 32'h102);
      misalign("lh_101", 1'b0, 2'd1, 32'h101);
      misalign("sz3_100", 1'b0, 2'd3, 32'h100);
      misalign("sw_101", 1'b1, 2'd2, 32'h101);
      misalign("sh_103", 1'b1, 2'd1, 32'h103);

      // Timeout: 4 WAIT cycles then timeout_err and rdata cleared
      push_mreq(32'h100, 1'b0, 1'b0, 4'h0, 32'h0);
      push_resp(K_TO, 1'b1, 32'h0);
      access("lw_timeout", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, -1, 32'h55555555, 5);

      // Ack in the 4th WAIT cycle wins over the timeout
      load("lw_ack4", 2'd2, 1'b0, 32'h100, 32'hCAFEF00D, 4, 32'hCAFEF00D);

      // Ack while idle is ignored
      @(posedge clk); #1;
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_mem_req", {31'd0, mem_req}, 32'd0);
      chk("idle_ack_stall", {31'd0, stall}, 32'd0);

      // Reset in the middle of WAIT abandons the transaction
      push_mreq(32'h300, 1'b0, 1'b0, 4'h0, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h300;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("wait_mem_req", {31'd0, mem_req}, 32'd1);
      #2;
      rst_b = 1'b0;
      #1;
      chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("async_rst_stall", {31'd0, stall}, 32'd0);
      chk("async_rst_rdata", rdata, 32'd0);
      chk("async_rst_mem_addr", mem_addr, 32'd0);
      @(posedge clk); #1;
      rst_b = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle", {30'd0, stall, mem_req}, 32'd0);
      end

      // The bench keeps working after reset
      store("sw_after_rst", 2'd2, 32'h104, 32'h0BADF00D, 1, 4'b1111, 32'h0BADF00D);

      repeat (4) @(posedge clk);
      chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
      chk("mreq_q_empty", 32'(mreq_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
